tone_sequencer: RTL

Three-note tone sequencer that drives the 8-bit address of the sine-table ROM feeding the audio DAC on GPIO_1. On a start pulse it plays three fixed tones, each followed by a silent gap. Each tone is generated by a 16-bit phase accumulator stepped at a fixed sample rate. It replaces the free-running address counter in the top level and exposes busy/done status for the robot control logic.

---
 rtl/tone_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/tone_sequencer.sv
// -----------------------------------------------------------------------------
// tone_sequencer
//
// Plays three fixed tones on a start pulse, each followed by a silent gap, by
// driving the 8-bit address of the sine-table ROM that feeds the audio DAC.
// Each tone comes from a 16-bit phase accumulator stepped once per sample tick;
// the ROM address is the top byte of the phase. ROM entry 0 is midscale, so
// rom_addr = 0 is silence.
//
// Optional feature macro: TONE_SEQ_LOOP_EN
//   defined   : after the last gap the sequence restarts at tone 0, done pulses
//               on every wrap, and busy stays high until stop or reset.
//   undefined : one-shot; returns to idle after the last gap.
//
// Ports:
//   CLOCK_50      in   1  system clock, 50 MHz
//   reset         in   1  synchronous, active-high
//   start         in   1  one-cycle request to begin the sequence (ignored when busy)
//   stop          in   1  synchronous abort, has priority over start
//   rom_addr      out  8  sine ROM address, registered
//   sample_strobe out  1  one-cycle pulse when rom_addr updates
//   tone_idx      out  2  current tone, 0..2
//   busy          out  1  high while the sequence is running
//   done          out  1  one-cycle pulse at sequence end
// -----------------------------------------------------------------------------
module tone_sequencer #(
    parameter int          SAMPLE_DIV = 500,
    parameter logic [15:0] TONE0_INC  = 16'd288,
    parameter logic [15:0] TONE1_INC  = 16'd343,
    parameter logic [15:0] TONE2_INC  = 16'd432,
    parameter int          TONE_TICKS = 50000,
    parameter int          GAP_TICKS  = 10000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] rom_addr,
    output logic       sample_strobe,
    output logic [1:0] tone_idx,
    output logic       busy,
    output logic       done
);

    localparam int                DIV_W     = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [15:0]       TONE_LAST = 16'(TONE_TICKS - 1);
    localparam logic [15:0]       GAP_LAST  = 16'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TONE = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           r_state,    w_state_nxt;
    logic [DIV_W-1:0] r_div,      w_div_nxt;
    logic [15:0]      r_phase,    w_phase_nxt;
    logic [15:0]      r_tick_cnt, w_tick_cnt_nxt;
    logic [1:0]       r_tone_idx, w_tone_idx_nxt;
    logic [7:0]       r_rom_addr, w_rom_addr_nxt;
    logic             r_strobe,   w_strobe_nxt;
    logic             r_done,     w_done_nxt;

    logic             w_tick;
    logic [15:0]      w_inc;
    logic [15:0]      w_phase_sum;

    always_comb begin
        case (r_tone_idx)
            2'd0:    w_inc = TONE0_INC;
            2'd1:    w_inc = TONE1_INC;
            default: w_inc = TONE2_INC;
        endcase
    end

    assign w_phase_sum = r_phase + w_inc;          // wraps mod 2^16
    assign w_tick      = (r_state != S_IDLE) && (r_div == '0);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_div      <= DIV_LOAD;
            r_phase    <= '0;
            r_tick_cnt <= '0;
            r_tone_idx <= '0;
            r_rom_addr <= '0;
            r_strobe   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_phase    <= w_phase_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_tone_idx <= w_tone_idx_nxt;
            r_rom_addr <= w_rom_addr_nxt;
            r_strobe   <= w_strobe_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_div_nxt      = r_div;
        w_phase_nxt    = r_phase;
        w_tick_cnt_nxt = r_tick_cnt;
        w_tone_idx_nxt = r_tone_idx;
        w_rom_addr_nxt = r_rom_addr;
        w_strobe_nxt   = 1'b0;
        w_done_nxt     = 1'b0;

        // Divider free-runs across TONE/GAP boundaries so strobe spacing
        // stays exactly SAMPLE_DIV cycles for the whole sequence.
        if (r_state != S_IDLE)
            w_div_nxt = w_tick ? DIV_LOAD : (r_div - DIV_W'(1));

        case (r_state)
            S_IDLE: begin
                w_div_nxt = DIV_LOAD;
                if (start) begin
                    w_state_nxt    = S_TONE;
                    w_phase_nxt    = '0;
                    w_tick_cnt_nxt = '0;
                    w_tone_idx_nxt = '0;
                    w_rom_addr_nxt = '0;
                end
            end
            S_TONE: begin
                if (w_tick) begin
                    w_strobe_nxt = 1'b1;
                    if (r_tick_cnt == TONE_LAST) begin
                        w_state_nxt    = S_GAP;
                        w_phase_nxt    = '0;
                        w_rom_addr_nxt = '0;
                        w_tick_cnt_nxt = '0;
                    end else begin
                        w_phase_nxt    = w_phase_sum;
                        w_rom_addr_nxt = w_phase_sum[15:8];
                        w_tick_cnt_nxt = r_tick_cnt + 16'd1;
                    end
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    w_strobe_nxt   = 1'b1;
                    w_rom_addr_nxt = '0;
                    if (r_tick_cnt == GAP_LAST) begin
                        w_tick_cnt_nxt = '0;
                        if (r_tone_idx < 2'd2) begin
                            w_tone_idx_nxt = r_tone_idx + 2'd1;
                            w_state_nxt    = S_TONE;
                        end else begin
                            w_tone_idx_nxt = '0;
                            w_done_nxt     = 1'b1;
`ifdef TONE_SEQ_LOOP_EN
                            w_state_nxt    = S_TONE;
`else
                            w_state_nxt    = S_IDLE;
`endif
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 16'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (stop) begin
            w_state_nxt    = S_IDLE;
            w_div_nxt      = DIV_LOAD;
            w_phase_nxt    = '0;
            w_tick_cnt_nxt = '0;
            w_tone_idx_nxt = '0;
            w_rom_addr_nxt = '0;
            w_strobe_nxt   = 1'b0;
            w_done_nxt     = 1'b0;
        end
    end

    assign rom_addr      = r_rom_addr;
    assign sample_strobe = r_strobe;
    assign tone_idx      = r_tone_idx;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;

endmodule
